hdd_pwr_seq: RTL and testbench
==============================

# hdd_pwr_seq

Hot-plug power sequencer for the 15 HDD slots of the HATTRICK sideplane CPLD. It sits downstream of the I2C register block: it consumes the host power-allow mask and fault-clear strobes, debounces the HDD insert pins, and powers drives one at a time with a stagger gap. It supervises 5 V/12 V power-good, and returns presence, fault and busy status for the register map and the LED blocks.

## Interface
- NUM_HDD, 15, number of slots; bit i = HDDi+1.
- DEB_CYCLES, 20000, SYSCLK cycles an insert pin must be stable before presence changes.
- STAGGER_CYCLES, 50000, idle gap after a drive is fully powered before the next enable.
- PG_TIMEOUT_CYCLES, 100000, maximum wait for both power-goods after enable.
- SYSCLK  in  1  single clock; all logic on rising edge.
- RESET_N  in  1  asynchronous, active-low reset.
- hdd_insert_l  in  NUM_HDD  raw HDDx_INSERT_L pins, asynchronous, low = inserted.
- p5v_gd  in  NUM_HDD  P5V_GD_HDDx, asynchronous, high = good.
- p12v_gd  in  NUM_HDD  P12V_GD_HDDx, asynchronous, high = good.
- pwr_allow  in  NUM_HDD  level from register block; 1 = host permits power.
- fault_clr  in  NUM_HDD  one-cycle strobe per bit; clears sticky fault.
- pwr_en_l  out  NUM_HDD  PWR_EN_HDDx_L, low = power on; registered.
- present  out  NUM_HDD  debounced presence, 1 = inserted.
- pwr_on  out  NUM_HDD  1 = enabled and both power-goods confirmed.
- pwr_fault  out  NUM_HDD  sticky fault: power-good timeout or loss.
- seq_busy  out  1  high in any FSM state other than IDLE.

## Operation
- Input conditioning:
  - Every insert and power-good bit passes through a 2-FF synchronizer.
  - Insert bits are then debounced. `present[i]` toggles only after the synchronized level differs from `present[i]` for DEB_CYCLES consecutive cycles.
  - Any bounce restarts that slot's counter.
- Slot eligibility: slot i is eligible when `present & pwr_allow & ~enabled & ~pwr_fault`.
- FSM states:
  - IDLE: on any eligible slot, go to SCAN.
  - SCAN: a round-robin pointer selects the lowest eligible index ≥ ptr, wrapping 14→0. Go to ENABLE.
  - ENABLE: drive `pwr_en_l[sel]` low, clear the timer, go to WAIT_PG.
  - WAIT_PG:
    - If both synchronized power-goods of sel are high, set `pwr_on[sel]`, set ptr = sel+1 (mod NUM_HDD), go to STAGGER.
    - If the timer reaches PG_TIMEOUT_CYCLES-1, drive `pwr_en_l[sel]` high, set `pwr_fault[sel]`, set ptr = sel+1, go to STAGGER.
  - STAGGER: count STAGGER_CYCLES, then go to IDLE.
- Power-off rules: these apply in every state and are checked per slot every cycle.
  - Triggers for slot i:
    - `present[i]` falls.
    - `pwr_allow[i]` falls.
    - `pwr_on[i]` is set and either power-good is low.
  - Response: `pwr_en_l[i]` goes high and `pwr_on[i]` is cleared on the next edge.
  - A power-good loss also sets `pwr_fault[i]`.
- Selected-slot abort: if the slot being sequenced hits a power-off trigger during WAIT_PG, the FSM goes straight to STAGGER. No fault is recorded unless the trigger was a power-good loss.
- Fault clearing:
  - `fault_clr[i]` clears `pwr_fault[i]`.
  - Removal (`present` falling) also clears it.
  - If a set and a clear land in the same cycle, the set wins.
- Re-enable: a slot powered off by the host or by removal becomes eligible again once its conditions hold. No retry happens while `pwr_fault` is set.

## Timing
- Reset values:
  - `pwr_en_l` = all 1s.
  - `present`, `pwr_on`, `pwr_fault` = 0.
  - `seq_busy` = 0, FSM = IDLE, ptr = 0, all counters = 0.
  - This also holds for a reset asserted mid-sequence: every enabled drive drops immediately and asynchronously.
- Insert edge to `present`: 2 synchronizer cycles + DEB_CYCLES, ±1 cycle.
- `present` rising to `pwr_en_l` low: 3 cycles if the FSM is idle (IDLE→SCAN→ENABLE→registered output).
- Power-good high at the pin to `pwr_on`: 3 cycles (2 sync + 1).
- Enable-to-enable spacing between successive slots: ≥ STAGGER_CYCLES + 3.
- Power-off response: 1 cycle after the trigger is seen post-sync.
- Counter widths: each counter is $clog2 of its maximum value; counters saturate and never wrap.

## Structure
- Shared constants go in hattrick_define.v: the NUM_HDD default and the cycle defaults for a 12.5 MHz SYSCLK.
- FSM state encodings are local parameters of this module.
- Sub-module `hdd_debounce`: one synchronizer plus debounce counter, parameterized by DEB_CYCLES, instantiated NUM_HDD times in a generate loop.
- Power-good synchronizers stay in the top module.

## Test plan
Bench parameters: DEB_CYCLES=4, STAGGER_CYCLES=8, PG_TIMEOUT_CYCLES=16.

- Reset, then `hdd_insert_l`=15'h7FFE and `pwr_allow`=all 1s, with HDD1 power-goods rising 5 cycles after enable → `pwr_en_l[0]` low 9±1 cycles after insert; `pwr_on[0]`=1; no fault.
- Insert 15'h0000 together, all power-goods follow enable after 2 cycles → enables assert in order 0,1,…,14, each spaced ≥11 cycles; `seq_busy` stays high throughout.
- HDD3 power-goods never rise → `pwr_en_l[2]` returns high at 16 cycles; `pwr_fault`=15'h0004; no retry. `fault_clr`=15'h0004 → slot re-sequenced.
- Powered HDD5 drops `p12v_gd[4]` → `pwr_en_l[4]` high within 3 cycles; `pwr_fault[4]`=1.
- HDD2 pulled during WAIT_PG, and separately with bounces shorter than 4 cycles on HDD7 → HDD2 enable drops and FSM goes to STAGGER without a fault; HDD7 `present` never toggles.
- `RESET_N` pulsed low during WAIT_PG with 3 drives on → all `pwr_en_l` high asynchronously; all status = 0. After release, the drives re-sequence from ptr=0.

Source files
------------

// File: rtl/hdd_pwr_seq_pkg.sv
// Shared constants, FSM state type and sizing helper for the HATTRICK HDD power sequencer.
// Cycle defaults assume a 12.5 MHz SYSCLK.
package hdd_pwr_seq_pkg;

    localparam int NUM_HDD_DEF           = 15;
    localparam int DEB_CYCLES_DEF        = 20000;   // 1.6 ms
    localparam int STAGGER_CYCLES_DEF    = 50000;   // 4 ms
    localparam int PG_TIMEOUT_CYCLES_DEF = 100000;  // 8 ms

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SCAN    = 3'd1,
        ST_ENABLE  = 3'd2,
        ST_WAIT_PG = 3'd3,
        ST_STAGGER = 3'd4
    } seq_state_t;

    // Counter width able to hold 0 .. max_val-1, never narrower than one bit.
    function automatic int cnt_width(input int max_val);
        if (max_val > 1) begin
            return $clog2(max_val);
        end else begin
            return 1;
        end
    endfunction

endpackage

// File: rtl/hdd_pwr_seq_debounce.sv
// One HDD insert pin: 2-FF synchronizer followed by a consecutive-cycle debounce counter.
// o_present flips only after the synchronized level disagrees with it for DEB_CYCLES cycles.
module hdd_debounce
    import hdd_pwr_seq_pkg::*;
#(
    parameter int DEB_CYCLES = DEB_CYCLES_DEF
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_insert_l,
    output logic o_present
);

    localparam int            CW      = cnt_width(DEB_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEB_CYCLES - 1);

    logic          r_meta;
    logic          r_sync;
    logic          r_present;
    logic [CW-1:0] r_cnt;
    logic          w_differs;

    assign w_differs = (~r_sync) ^ r_present;

    // Synchronize the pin, then count agreement breaks; any bounce restarts the count.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_meta    <= 1'b1;
            r_sync    <= 1'b1;
            r_present <= 1'b0;
            r_cnt     <= {CW{1'b0}};
        end else begin
            r_meta <= i_insert_l;
            r_sync <= r_meta;
            if (w_differs) begin
                if (r_cnt == CNT_MAX) begin
                    r_present <= ~r_present;
                    r_cnt     <= {CW{1'b0}};
                end else begin
                    r_cnt <= r_cnt + CW'(1);
                end
            end else begin
                r_cnt <= {CW{1'b0}};
            end
        end
    end

    assign o_present = r_present;

endmodule

// File: rtl/hdd_pwr_seq.sv
// Hot-plug power sequencer for the HATTRICK sideplane: powers eligible HDD slots one at a time
// in round-robin order with a stagger gap, and supervises 5 V / 12 V power-good per slot.
module hdd_pwr_seq
    import hdd_pwr_seq_pkg::*;
#(
    parameter int NUM_HDD           = NUM_HDD_DEF,
    parameter int DEB_CYCLES        = DEB_CYCLES_DEF,
    parameter int STAGGER_CYCLES    = STAGGER_CYCLES_DEF,
    parameter int PG_TIMEOUT_CYCLES = PG_TIMEOUT_CYCLES_DEF
) (
    input  logic               SYSCLK,
    input  logic               RESET_N,
    input  logic [NUM_HDD-1:0] hdd_insert_l,
    input  logic [NUM_HDD-1:0] p5v_gd,
    input  logic [NUM_HDD-1:0] p12v_gd,
    input  logic [NUM_HDD-1:0] pwr_allow,
    input  logic [NUM_HDD-1:0] fault_clr,
    output logic [NUM_HDD-1:0] pwr_en_l,
    output logic [NUM_HDD-1:0] present,
    output logic [NUM_HDD-1:0] pwr_on,
    output logic [NUM_HDD-1:0] pwr_fault,
    output logic               seq_busy
);

    localparam int            PW      = cnt_width(NUM_HDD);
    localparam int            TW      = cnt_width(PG_TIMEOUT_CYCLES);
    localparam int            SW      = cnt_width(STAGGER_CYCLES);
    localparam logic [TW-1:0] TO_MAX  = TW'(PG_TIMEOUT_CYCLES - 1);
    localparam logic [SW-1:0] STG_MAX = SW'(STAGGER_CYCLES - 1);
    localparam logic [NUM_HDD-1:0] ZERO_V = {NUM_HDD{1'b0}};

    seq_state_t         r_state;
    logic [PW-1:0]      r_ptr;
    logic [PW-1:0]      r_sel;
    logic [TW-1:0]      r_timer;
    logic [SW-1:0]      r_stg;
    logic               r_busy;
    logic [NUM_HDD-1:0] r_pg5_m, r_pg5, r_pg12_m, r_pg12;
    logic [NUM_HDD-1:0] r_present_q;
    logic [NUM_HDD-1:0] r_pwr_en_l, r_pwr_on, r_pwr_fault;

    logic [NUM_HDD-1:0] w_present, w_pg_ok, w_pres_fall, w_pg_loss, w_off, w_elig;
    logic [NUM_HDD-1:0] w_sel_oh, w_fsm_en, w_fsm_on, w_fsm_to;
    logic [PW-1:0]      w_pick, w_sel_next;
    logic               w_found, w_sel_live, w_sel_good, w_sel_to;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_HDD; gi++) begin : g_deb
            hdd_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
                .i_clk      (SYSCLK),
                .i_rst_n    (RESET_N),
                .i_insert_l (hdd_insert_l[gi]),
                .o_present  (w_present[gi])
            );
        end
    endgenerate

    assign w_pg_ok     = r_pg5 & r_pg12;
    assign w_pres_fall = r_present_q & ~w_present;
    assign w_pg_loss   = r_pwr_on & ~w_pg_ok;
    // Power-off is level based on enabled slots so a removal/deny racing an enable still wins.
    assign w_off       = (~r_pwr_en_l & ~(w_present & pwr_allow)) | w_pg_loss;
    assign w_elig      = w_present & pwr_allow & r_pwr_en_l & ~r_pwr_fault;

    assign w_sel_oh    = {{(NUM_HDD-1){1'b0}}, 1'b1} << r_sel;
    assign w_sel_next  = (r_sel == PW'(NUM_HDD - 1)) ? {PW{1'b0}} : r_sel + PW'(1);
    assign w_sel_live  = ~r_pwr_en_l[r_sel] & ~w_off[r_sel];
    assign w_sel_good  = w_sel_live & w_pg_ok[r_sel];
    assign w_sel_to    = w_sel_live & ~w_pg_ok[r_sel] & (r_timer == TO_MAX);

    // Round-robin pick: lowest eligible index at or above ptr, wrapping to 0.
    always_comb begin
        logic [PW:0] v_idx;
        v_idx   = {(PW+1){1'b0}};
        w_pick  = {PW{1'b0}};
        w_found = 1'b0;
        for (int k = 0; k < NUM_HDD; k++) begin
            v_idx = {1'b0, r_ptr} + (PW+1)'(k);
            if (v_idx >= (PW+1)'(NUM_HDD)) begin
                v_idx = v_idx - (PW+1)'(NUM_HDD);
            end else begin
                v_idx = v_idx;
            end
            if (!w_found && w_elig[v_idx[PW-1:0]]) begin
                w_pick  = v_idx[PW-1:0];
                w_found = 1'b1;
            end else begin
                w_pick  = w_pick;
            end
        end
    end

    // Per-slot effects of the current FSM state on the selected slot.
    always_comb begin
        w_fsm_en = ZERO_V;
        w_fsm_on = ZERO_V;
        w_fsm_to = ZERO_V;
        if (r_state == ST_ENABLE && w_elig[r_sel]) begin
            w_fsm_en = w_sel_oh;
        end else if (r_state == ST_WAIT_PG && w_sel_good) begin
            w_fsm_on = w_sel_oh;
        end else if (r_state == ST_WAIT_PG && w_sel_to) begin
            w_fsm_to = w_sel_oh;
        end else begin
            w_fsm_en = ZERO_V;
        end
    end

    // Power-good synchronizers and slot status vectors; fault set beats clear.
    always_ff @(posedge SYSCLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_pg5_m     <= ZERO_V;
            r_pg5       <= ZERO_V;
            r_pg12_m    <= ZERO_V;
            r_pg12      <= ZERO_V;
            r_present_q <= ZERO_V;
            r_pwr_en_l  <= {NUM_HDD{1'b1}};
            r_pwr_on    <= ZERO_V;
            r_pwr_fault <= ZERO_V;
        end else begin
            r_pg5_m     <= p5v_gd;
            r_pg5       <= r_pg5_m;
            r_pg12_m    <= p12v_gd;
            r_pg12      <= r_pg12_m;
            r_present_q <= w_present;
            r_pwr_en_l  <= (r_pwr_en_l & ~w_fsm_en) | w_off | w_fsm_to;
            r_pwr_on    <= (r_pwr_on | w_fsm_on) & ~w_off;
            r_pwr_fault <= (r_pwr_fault & ~(fault_clr | w_pres_fall)) | w_pg_loss | w_fsm_to;
        end
    end

    // Sequencer FSM. STAGGER hands straight to SCAN when work is pending so busy stays high.
    always_ff @(posedge SYSCLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_state <= ST_IDLE;
            r_ptr   <= {PW{1'b0}};
            r_sel   <= {PW{1'b0}};
            r_timer <= {TW{1'b0}};
            r_stg   <= {SW{1'b0}};
            r_busy  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (|w_elig) begin
                        r_state <= ST_SCAN;
                        r_busy  <= 1'b1;
                    end else begin
                        r_busy  <= 1'b0;
                    end
                end
                ST_SCAN: begin
                    if (w_found) begin
                        r_sel   <= w_pick;
                        r_state <= ST_ENABLE;
                    end else begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                ST_ENABLE: begin
                    r_timer <= {TW{1'b0}};
                    if (w_elig[r_sel]) begin
                        r_state <= ST_WAIT_PG;
                    end else begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                ST_WAIT_PG: begin
                    if (!w_sel_live || w_sel_good || w_sel_to) begin
                        r_ptr   <= w_sel_next;
                        r_stg   <= {SW{1'b0}};
                        r_state <= ST_STAGGER;
                    end else if (r_timer != TO_MAX) begin
                        r_timer <= r_timer + TW'(1);
                    end else begin
                        r_timer <= r_timer;
                    end
                end
                ST_STAGGER: begin
                    if (r_stg == STG_MAX) begin
                        r_stg <= {SW{1'b0}};
                        if (|w_elig) begin
                            r_state <= ST_SCAN;
                        end else begin
                            r_state <= ST_IDLE;
                            r_busy  <= 1'b0;
                        end
                    end else begin
                        r_stg <= r_stg + SW'(1);
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign pwr_en_l  = r_pwr_en_l;
    assign present   = w_present;
    assign pwr_on    = r_pwr_on;
    assign pwr_fault = r_pwr_fault;
    assign seq_busy  = r_busy;

endmodule

// File: tb/tb_hdd_pwr_seq.sv
// Self-checking bench for hdd_pwr_seq with short debounce/stagger/timeout parameters.
// A drive model answers enables with power-good after a per-slot delay.
module tb_hdd_pwr_seq;

    localparam int N    = 15;
    localparam int DEB  = 4;
    localparam int STG  = 8;
    localparam int PGTO = 16;

    logic         SYSCLK = 1'b0;
    logic         RESET_N;
    logic [N-1:0] hdd_insert_l, p5v_gd, p12v_gd, pwr_allow, fault_clr;
    logic [N-1:0] pwr_en_l, present, pwr_on, pwr_fault;
    logic         seq_busy;

    int n_pass  = 0;
    int n_total = 0;

    int pg_delay [N];
    bit pg_never [N];
    bit kill12   [N];
    int en_age   [N];

    hdd_pwr_seq #(.NUM_HDD(N), .DEB_CYCLES(DEB), .STAGGER_CYCLES(STG), .PG_TIMEOUT_CYCLES(PGTO)) dut (
        .SYSCLK(SYSCLK), .RESET_N(RESET_N), .hdd_insert_l(hdd_insert_l), .p5v_gd(p5v_gd),
        .p12v_gd(p12v_gd), .pwr_allow(pwr_allow), .fault_clr(fault_clr), .pwr_en_l(pwr_en_l),
        .present(present), .pwr_on(pwr_on), .pwr_fault(pwr_fault), .seq_busy(seq_busy)
    );

    always #5 SYSCLK = ~SYSCLK;

    // Drive model: power-goods rise pg_delay cycles into an enable, drop when enable goes away.
    initial begin
        p5v_gd  = '0;
        p12v_gd = '0;
        for (int i = 0; i < N; i++) en_age[i] = 0;
        forever begin
            @(posedge SYSCLK);
            #2;
            for (int i = 0; i < N; i++) begin
                if (pwr_en_l[i] === 1'b0) en_age[i]++;
                else en_age[i] = 0;
                p5v_gd[i]  = !pg_never[i] && (en_age[i] >= pg_delay[i]) && (en_age[i] > 0);
                p12v_gd[i] = p5v_gd[i] && !kill12[i];
            end
        end
    end

    // Reference round-robin rule: lowest eligible index at or above ptr, wrapping.
    function automatic int rr_next(input logic [N-1:0] elig, input int ptr);
        for (int k = 0; k < N; k++) if (elig[(ptr + k) % N]) return (ptr + k) % N;
        return -1;
    endfunction

    task automatic do_reset();
        RESET_N      = 1'b0;
        hdd_insert_l = '1;
        pwr_allow    = '1;
        fault_clr    = '0;
        for (int i = 0; i < N; i++) begin
            pg_delay[i] = 2; pg_never[i] = 1'b0; kill12[i] = 1'b0;
        end
        repeat (3) @(negedge SYSCLK);
        RESET_N = 1'b1;
        repeat (2) @(negedge SYSCLK);
    endtask

    task automatic test_reset();
        do_reset();
        n_total++; if (pwr_en_l !== 15'h7FFF) $display("FAIL reset_en_l: got %h want 7fff", pwr_en_l); else n_pass++;
        n_total++; if (present !== 15'h0000) $display("FAIL reset_present: got %h want 0000", present); else n_pass++;
        n_total++; if (pwr_on !== 15'h0000) $display("FAIL reset_pwr_on: got %h want 0000", pwr_on); else n_pass++;
        n_total++; if (pwr_fault !== 15'h0000) $display("FAIL reset_fault: got %h want 0000", pwr_fault); else n_pass++;
        n_total++; if (seq_busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", seq_busy); else n_pass++;
    endtask

    task automatic test_single();
        int c, t_pres, t_en;
        do_reset();
        pg_delay[0] = 5;
        hdd_insert_l = 15'h7FFE;
        c = 0; t_pres = -1; t_en = -1;
        while (t_en < 0 && c < 40) begin
            @(negedge SYSCLK); c++;
            if (t_pres < 0 && present[0] === 1'b1) t_pres = c;
            if (pwr_en_l[0] === 1'b0) t_en = c;
        end
        n_total++; if (t_pres < 2 + DEB - 1 || t_pres > 2 + DEB + 1) $display("FAIL single_present_lat: got %0d want %0d+-1", t_pres, 2 + DEB); else n_pass++;
        n_total++; if (t_en < 2 + DEB + 2 || t_en > 2 + DEB + 4) $display("FAIL single_en_lat: got %0d want %0d+-1", t_en, 2 + DEB + 3); else n_pass++;
        c = 0;
        while (pwr_on[0] !== 1'b1 && c < 40) begin @(negedge SYSCLK); c++; end
        n_total++; if (c != pg_delay[0] - 1 + 3) $display("FAIL single_pwr_on_lat: got %0d want %0d", c, pg_delay[0] + 2); else n_pass++;
        n_total++; if (pwr_on !== 15'h0001) $display("FAIL single_pwr_on: got %h want 0001", pwr_on); else n_pass++;
        n_total++; if (pwr_fault !== 15'h0000) $display("FAIL single_fault: got %h want 0000", pwr_fault); else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [N-1:0] remaining, prev, newly, exp_oh;
        int ptr_m, last_t, c, seen, busy_low, exp;
        do_reset();
        for (int i = 0; i < N; i++) pg_delay[i] = $urandom_range(1, 6);
        hdd_insert_l = 15'h0000;
        remaining = '1; prev = '1; ptr_m = 0; last_t = -1; c = 0; seen = 0; busy_low = 0;
        while (seen < N && c < 2000) begin
            @(negedge SYSCLK); c++;
            if (seen > 0 && seq_busy !== 1'b1) busy_low++;
            newly = prev & ~pwr_en_l;
            prev  = pwr_en_l;
            if (newly != '0) begin
                exp = rr_next(remaining, ptr_m);
                exp_oh = '0;
                if (exp >= 0) exp_oh[exp] = 1'b1;
                n_total++; if (newly !== exp_oh) $display("FAIL b2b_order: got %h want %h", newly, exp_oh); else n_pass++;
                if (last_t >= 0) begin
                    n_total++; if (c - last_t < STG + 3) $display("FAIL b2b_spacing: got %0d want >=%0d", c - last_t, STG + 3); else n_pass++;
                end
                if (exp >= 0) begin remaining[exp] = 1'b0; ptr_m = (exp + 1) % N; end
                last_t = c; seen++;
            end
        end
        n_total++; if (seen != N) $display("FAIL b2b_timeout: got %0d enables want %0d", seen, N); else n_pass++;
        n_total++; if (busy_low != 0) $display("FAIL b2b_busy: got %0d idle cycles want 0", busy_low); else n_pass++;
        c = 0;
        while (pwr_on !== 15'h7FFF && c < 100) begin @(negedge SYSCLK); c++; end
        n_total++; if (pwr_on !== 15'h7FFF) $display("FAIL b2b_all_on: got %h want 7fff", pwr_on); else n_pass++;
    endtask

    task automatic test_timeout();
        int c, relow;
        do_reset();
        pg_never[2] = 1'b1;
        hdd_insert_l = 15'h7FFB;
        c = 0;
        while (pwr_en_l[2] !== 1'b0 && c < 30) begin @(negedge SYSCLK); c++; end
        c = 0;
        while (pwr_en_l[2] !== 1'b1 && c < 40) begin @(negedge SYSCLK); c++; end
        n_total++; if (c != PGTO) $display("FAIL timeout_len: got %0d want %0d", c, PGTO); else n_pass++;
        n_total++; if (pwr_fault !== 15'h0004) $display("FAIL timeout_fault: got %h want 0004", pwr_fault); else n_pass++;
        relow = 0;
        repeat (40) begin @(negedge SYSCLK); if (pwr_en_l[2] !== 1'b1) relow++; end
        n_total++; if (relow != 0) $display("FAIL timeout_no_retry: got %0d enabled cycles want 0", relow); else n_pass++;
        pg_never[2] = 1'b0;
        fault_clr = 15'h0004;
        @(negedge SYSCLK);
        fault_clr = 15'h0000;
        c = 1;
        while (pwr_en_l[2] !== 1'b0 && c < 20) begin @(negedge SYSCLK); c++; end
        n_total++; if (c > 5) $display("FAIL timeout_reseq: got %0d cycles want <=5", c); else n_pass++;
        c = 0;
        while (pwr_on[2] !== 1'b1 && c < 20) begin @(negedge SYSCLK); c++; end
        n_total++; if (pwr_on !== 15'h0004 || pwr_fault !== 15'h0000) $display("FAIL timeout_recover: got on=%h fault=%h want 0004/0000", pwr_on, pwr_fault); else n_pass++;
    endtask

    task automatic test_pg_loss();
        int c, relow;
        do_reset();
        hdd_insert_l = 15'h7FEF;
        c = 0;
        while (pwr_on[4] !== 1'b1 && c < 40) begin @(negedge SYSCLK); c++; end
        n_total++; if (pwr_on !== 15'h0010) $display("FAIL pgloss_on: got %h want 0010", pwr_on); else n_pass++;
        kill12[4] = 1'b1;
        c = 0;
        while (p12v_gd[4] !== 1'b0 && c < 5) begin @(negedge SYSCLK); c++; end
        c = 0;
        while (pwr_en_l[4] !== 1'b1 && c < 10) begin @(negedge SYSCLK); c++; end
        n_total++; if (c < 1 || c > 3) $display("FAIL pgloss_lat: got %0d want 1..3", c); else n_pass++;
        n_total++; if (pwr_fault !== 15'h0010 || pwr_on !== 15'h0000) $display("FAIL pgloss_status: got fault=%h on=%h want 0010/0000", pwr_fault, pwr_on); else n_pass++;
        relow = 0;
        repeat (30) begin @(negedge SYSCLK); if (pwr_en_l[4] !== 1'b1) relow++; end
        n_total++; if (relow != 0) $display("FAIL pgloss_no_retry: got %0d enabled cycles want 0", relow); else n_pass++;
    endtask

    task automatic test_pull_and_bounce();
        int c, viol;
        do_reset();
        pg_never[1] = 1'b1;
        hdd_insert_l = 15'h7FFD;
        c = 0;
        while (pwr_en_l[1] !== 1'b0 && c < 30) begin @(negedge SYSCLK); c++; end
        repeat ($urandom_range(0, 6)) @(negedge SYSCLK);
        hdd_insert_l[1] = 1'b1;
        c = 0;
        while (pwr_en_l[1] !== 1'b1 && c < 30) begin @(negedge SYSCLK); c++; end
        n_total++; if (c < 2 + DEB || c > 2 + DEB + 2) $display("FAIL pull_lat: got %0d want %0d+-1", c, 2 + DEB + 1); else n_pass++;
        n_total++; if (pwr_fault !== 15'h0000) $display("FAIL pull_fault: got %h want 0000", pwr_fault); else n_pass++;
        n_total++; if (seq_busy !== 1'b1) $display("FAIL pull_stagger: got busy=%b want 1", seq_busy); else n_pass++;
        viol = 0;
        for (int b = 0; b < 8; b++) begin
            hdd_insert_l[6] = 1'b0;
            repeat ($urandom_range(1, DEB - 1)) begin @(negedge SYSCLK); if (present[6] !== 1'b0) viol++; end
            hdd_insert_l[6] = 1'b1;
            repeat ($urandom_range(1, 3)) begin @(negedge SYSCLK); if (present[6] !== 1'b0) viol++; end
        end
        repeat (10) begin @(negedge SYSCLK); if (present[6] !== 1'b0) viol++; end
        n_total++; if (viol != 0) $display("FAIL bounce_present: got %0d toggled cycles want 0", viol); else n_pass++;
        n_total++; if (seq_busy !== 1'b0 || pwr_en_l !== 15'h7FFF) $display("FAIL pull_settle: got busy=%b en_l=%h want 0/7fff", seq_busy, pwr_en_l); else n_pass++;
    endtask

    task automatic test_wrap();
        logic [N-1:0] m, remaining, prev, newly, exp_oh;
        int s, a, b, c, seen, ptr_m, exp;
        do_reset();
        s = $urandom_range(3, 11); a = $urandom_range(0, s - 1); b = $urandom_range(s + 1, N - 1);
        m = '0; m[s] = 1'b1;
        hdd_insert_l = ~m;
        c = 0;
        while (pwr_on[s] !== 1'b1 && c < 60) begin @(negedge SYSCLK); c++; end
        m[a] = 1'b1; m[b] = 1'b1;
        hdd_insert_l = ~m;
        remaining = '0; remaining[a] = 1'b1; remaining[b] = 1'b1;
        ptr_m = (s + 1) % N; prev = pwr_en_l; seen = 0; c = 0;
        while (seen < 2 && c < 300) begin
            @(negedge SYSCLK); c++;
            newly = prev & ~pwr_en_l;
            prev  = pwr_en_l;
            if (newly != '0) begin
                exp = rr_next(remaining, ptr_m);
                exp_oh = '0; exp_oh[exp] = 1'b1;
                n_total++; if (newly !== exp_oh) $display("FAIL wrap_order: got %h want %h (s=%0d)", newly, exp_oh, s); else n_pass++;
                remaining[exp] = 1'b0; ptr_m = (exp + 1) % N; seen++;
            end
        end
        n_total++; if (seen != 2) $display("FAIL wrap_timeout: got %0d enables want 2", seen); else n_pass++;
    endtask

    task automatic test_reset_mid();
        logic [N-1:0] remaining, prev, newly, exp_oh;
        int c, seen, ptr_m, exp;
        do_reset();
        pg_never[3] = 1'b1;
        hdd_insert_l = 15'h7FF0;
        c = 0;
        while (!(pwr_on[2:0] === 3'b111 && pwr_en_l[3] === 1'b0) && c < 300) begin @(negedge SYSCLK); c++; end
        n_total++; if (c >= 300) $display("FAIL rstmid_setup: got timeout want 3 on + slot3 waiting"); else n_pass++;
        @(negedge SYSCLK);
        #2 RESET_N = 1'b0;
        #1;
        n_total++; if (pwr_en_l !== 15'h7FFF) $display("FAIL rstmid_en_l: got %h want 7fff", pwr_en_l); else n_pass++;
        n_total++; if ({present, pwr_on, pwr_fault} !== 45'd0 || seq_busy !== 1'b0) $display("FAIL rstmid_status: got pres=%h on=%h fault=%h busy=%b want all 0", present, pwr_on, pwr_fault, seq_busy); else n_pass++;
        repeat (2) @(negedge SYSCLK);
        RESET_N = 1'b1;
        remaining = 15'h000F; ptr_m = 0; prev = pwr_en_l; seen = 0; c = 0;
        while (seen < 2 && c < 200) begin
            @(negedge SYSCLK); c++;
            newly = prev & ~pwr_en_l;
            prev  = pwr_en_l;
            if (newly != '0) begin
                exp = rr_next(remaining, ptr_m);
                exp_oh = '0; exp_oh[exp] = 1'b1;
                n_total++; if (newly !== exp_oh) $display("FAIL rstmid_order: got %h want %h", newly, exp_oh); else n_pass++;
                remaining[exp] = 1'b0; ptr_m = (exp + 1) % N; seen++;
            end
        end
        n_total++; if (seen != 2) $display("FAIL rstmid_timeout: got %0d enables want 2", seen); else n_pass++;
    endtask

    initial begin
        RESET_N      = 1'b0;
        hdd_insert_l = '1;
        pwr_allow    = '1;
        fault_clr    = '0;
        for (int i = 0; i < N; i++) begin pg_delay[i] = 2; pg_never[i] = 1'b0; kill12[i] = 1'b0; end
        test_reset();
        test_single();
        test_back_to_back();
        test_timeout();
        test_pg_loss();
        test_pull_and_bounce();
        test_wrap();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
